// File: rtl/size_field_patcher.sv
// -----------------------------------------------------------------------------
// size_field_patcher
// Receives size back-patch requests (offset/value/byte count) from the slice
// sequencer. It queues them in a small FIFO and turns each one into big-endian
// byte writes on the output-frame memory write port.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   offset_addr, val          field offset (relative to base_addr) and value
//   byte_size                 field width 1..4; a nonzero value is a one-cycle request
//   base_addr                 frame base, sampled together with each request
//   mem_wr_en/addr/data       registered byte write port
//   mem_wr_ready              memory accepts a byte while high with mem_wr_en
//   busy                      FIFO non-empty or a patch being written
//   overflow, bad_size        sticky drop flags (FIFO full / width > 4)
//   patch_count               completed patches, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module size_field_patcher #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      offset_addr,
    input  logic [31:0]      val,
    input  logic [31:0]      byte_size,
    input  logic [31:0]      base_addr,
    output logic             mem_wr_en,
    output logic [31:0]      mem_wr_addr,
    output logic [7:0]       mem_wr_data,
    input  logic             mem_wr_ready,
    output logic             busy,
    output logic             overflow,
    output logic             bad_size,
    output logic [CNT_W-1:0] patch_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Picks byte idx of a size-byte field, counting from the most significant byte.
    function automatic logic [7:0] byte_sel(input logic [31:0] v,
                                            input logic [2:0]  size,
                                            input logic [1:0]  idx);
        logic [2:0] pos;
        pos = size - 3'd1 - {1'b0, idx};
        return v[{pos[1:0], 3'b000} +: 8];
    endfunction

    logic [31:0]      fifo_addr_q [DEPTH];
    logic [31:0]      fifo_val_q  [DEPTH];
    logic [2:0]       fifo_size_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      addr_w_q, addr_w_d;
    logic [31:0]      val_w_q, val_w_d;
    logic [2:0]       size_w_q, size_w_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             overflow_q, bad_size_q;
    logic [CNT_W-1:0] patch_count_q;

    logic             req_valid_s, size_ok_s, full_s, push_s, pop_s, done_s;
    logic [31:0]      head_addr_s, head_val_s;
    logic [2:0]       head_size_s;

    // Request classification; fullness uses the registered count only.
    always_comb begin
        req_valid_s = (byte_size != 32'd0);
        size_ok_s   = (byte_size <= 32'd4);
        full_s      = (count_q == (PW+1)'(DEPTH));
        push_s      = req_valid_s && size_ok_s && !full_s;
        head_addr_s = fifo_addr_q[rd_ptr_q];
        head_val_s  = fifo_val_q[rd_ptr_q];
        head_size_s = fifo_size_q[rd_ptr_q];
    end

    // Next-state and next-output logic for the byte serialiser.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_w_d  = addr_w_q;
        val_w_d   = val_w_q;
        size_w_d  = size_w_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop_s     = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_d = 1'b0;
                if (count_q != '0) begin
                    pop_s = 1'b1;
                end else begin
                    pop_s = 1'b0;
                end
            end
            WRITE: begin
                if (mem_wr_ready) begin
                    if ({1'b0, idx_q} == size_w_q - 3'd1) begin
                        done_s = 1'b1;
                        if (count_q != '0) begin
                            // Back-to-back patch: load the next head with no idle cycle.
                            pop_s = 1'b1;
                        end else begin
                            state_d = IDLE;
                            wr_en_d = 1'b0;
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        wr_addr_d = addr_w_q + {30'd0, idx_d};
                        wr_data_d = byte_sel(val_w_q, size_w_q, idx_d);
                    end
                end else begin
                    // Stalled: hold address, data and enable.
                    wr_en_d = wr_en_q;
                end
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
            end
        endcase
        if (pop_s) begin
            state_d   = WRITE;
            idx_d     = 2'd0;
            addr_w_d  = head_addr_s;
            val_w_d   = head_val_s;
            size_w_d  = head_size_s;
            wr_en_d   = 1'b1;
            wr_addr_d = head_addr_s;
            wr_data_d = byte_sel(head_val_s, head_size_s, 2'd0);
        end else begin
            wr_en_d = wr_en_d;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= 32'd0;
                fifo_val_q[i]  <= 32'd0;
                fifo_size_q[i] <= 3'd0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= base_addr + offset_addr;
                fifo_val_q[wr_ptr_q]  <= val;
                fifo_size_q[wr_ptr_q] <= byte_size[2:0];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Serialiser state, working copy of the active patch, and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            addr_w_q  <= 32'd0;
            val_w_q   <= 32'd0;
            size_w_q  <= 3'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 32'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_w_q  <= addr_w_d;
            val_w_q   <= val_w_d;
            size_w_q  <= size_w_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Sticky drop flags and the completed-patch counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q    <= 1'b0;
            bad_size_q    <= 1'b0;
            patch_count_q <= '0;
        end else begin
            overflow_q    <= overflow_q | (req_valid_s && size_ok_s && full_s);
            bad_size_q    <= bad_size_q | (req_valid_s && !size_ok_s);
            patch_count_q <= patch_count_q + {{(CNT_W-1){1'b0}}, done_s};
        end
    end

    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign busy        = (count_q != '0) | (state_q == WRITE);
    assign overflow    = overflow_q;
    assign bad_size    = bad_size_q;
    assign patch_count = patch_count_q;

endmodule

// File: tb/tb_size_field_patcher.sv
module tb_size_field_patcher;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      offset_addr = 32'd0;
    logic [31:0]      val = 32'd0;
    logic [31:0]      byte_size = 32'd0;
    logic [31:0]      base_addr = 32'd0;
    logic             mem_wr_en;
    logic [31:0]      mem_wr_addr;
    logic [7:0]       mem_wr_data;
    logic             mem_wr_ready = 1'b1;
    logic             busy;
    logic             overflow;
    logic             bad_size;
    logic [CNT_W-1:0] patch_count;

    size_field_patcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .offset_addr  (offset_addr),
        .val          (val),
        .byte_size    (byte_size),
        .base_addr    (base_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .busy         (busy),
        .overflow     (overflow),
        .bad_size     (bad_size),
        .patch_count  (patch_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    // Reference model: pending request queue plus the byte writes still owed
    // for the patch currently being emitted.
    typedef struct {
        logic [31:0] a;
        logic [31:0] v;
        int          s;
    } req_t;

    req_t        m_pend[$];
    logic [31:0] m_waddr[$];
    logic [7:0]  m_wdata[$];
    int          m_pc = 0;
    bit          m_ovf = 1'b0;
    bit          m_bad = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_load(input req_t r);
        for (int i = 0; i < r.s; i++) begin
            m_waddr.push_back(r.a + 32'(i));
            m_wdata.push_back(8'((r.v >> (8 * (r.s - 1 - i))) & 32'hff));
        end
    endtask

    task automatic model_clear();
        m_pend.delete();
        m_waddr.delete();
        m_wdata.delete();
        m_pc  = 0;
        m_ovf = 1'b0;
        m_bad = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] bs, input logic [31:0] off,
                              input logic [31:0] v, input logic [31:0] base, input logic rdy);
        bit full;
        req_t r;
        full = (m_pend.size() == DEPTH);
        if (m_waddr.size() != 0) begin
            if (rdy) begin
                void'(m_waddr.pop_front());
                void'(m_wdata.pop_front());
                if (m_waddr.size() == 0) begin
                    m_pc++;
                    if (m_pend.size() != 0) model_load(m_pend.pop_front());
                end
            end
        end else if (m_pend.size() != 0) begin
            model_load(m_pend.pop_front());
        end
        if (bs != 32'd0) begin
            if (bs > 32'd4) m_bad = 1'b1;
            else if (full) m_ovf = 1'b1;
            else begin
                r.a = base + off;
                r.v = v;
                r.s = int'(bs);
                m_pend.push_back(r);
            end
        end
    endtask

    task automatic compare();
        chk("wr_en", {31'd0, mem_wr_en}, {31'd0, m_waddr.size() != 0});
        if (m_waddr.size() != 0) begin
            chk("wr_addr", mem_wr_addr, m_waddr[0]);
            chk("wr_data", {24'd0, mem_wr_data}, {24'd0, m_wdata[0]});
        end
        chk("busy", {31'd0, busy}, {31'd0, (m_pend.size() != 0) || (m_waddr.size() != 0)});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("bad_size", {31'd0, bad_size}, {31'd0, m_bad});
        chk("patch_count", 32'(patch_count), 32'(m_pc % (1 << CNT_W)));
    endtask

    // One clock cycle: drive inputs, advance DUT and model together, then compare.
    task automatic step(input logic [31:0] bs, input logic [31:0] off, input logic [31:0] v,
                        input logic [31:0] base, input logic rdy);
        byte_size    = bs;
        offset_addr  = off;
        val          = v;
        base_addr    = base;
        mem_wr_ready = rdy;
        @(posedge clock);
        model_edge(bs, off, v, base, rdy);
        #1;
        byte_size = 32'd0;
        compare();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_patch_count", 32'(patch_count), 32'd0);
        chk("rst_flags", {30'd0, overflow, bad_size}, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] bs;
        int r;
        int guard;

        // Power-on reset.
        #1;
        chk("por_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("por_patch_count", 32'(patch_count), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(1, 1'b1);

        // Two-byte patch with ready held high: bytes land at T+2 and T+3.
        step(32'd2, 32'h10, 32'h1234, 32'h1000, 1'b1);
        idle(1, 1'b1);
        chk("t1_en_T2", {31'd0, mem_wr_en}, 32'd1);
        chk("t1_addr0", mem_wr_addr, 32'h1010);
        chk("t1_data0", {24'd0, mem_wr_data}, 32'h12);
        idle(1, 1'b1);
        chk("t1_addr1", mem_wr_addr, 32'h1011);
        chk("t1_data1", {24'd0, mem_wr_data}, 32'h34);
        idle(1, 1'b1);
        chk("t1_busy_T4", {31'd0, busy}, 32'd0);
        chk("t1_count", 32'(patch_count), 32'd1);

        // Four-byte patch, stalled for three cycles on byte 1.
        step(32'd4, 32'd0, 32'hAABBCCDD, 32'd0, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);
        chk("t2_hold_addr", mem_wr_addr, 32'd1);
        chk("t2_hold_data", {24'd0, mem_wr_data}, 32'hBB);
        idle(4, 1'b1);

        // Oversized request is dropped; the next one still goes through.
        step(32'd7, 32'h20, 32'h55, 32'h0, 1'b1);
        idle(2, 1'b1);
        chk("t4_bad", {31'd0, bad_size}, 32'd1);
        chk("t4_no_write", {31'd0, mem_wr_en}, 32'd0);
        step(32'd1, 32'h30, 32'h77, 32'h100, 1'b1);
        idle(3, 1'b1);

        // Five queued requests while stalled, a sixth overflows, then drain.
        step(32'd2, 32'h00, 32'h0102, 32'h2000, 1'b0);
        step(32'd4, 32'h02, 32'h03040506, 32'h2000, 1'b0);
        step(32'd4, 32'h06, 32'h0708090A, 32'h2000, 1'b0);
        step(32'd2, 32'h0A, 32'h0B0C, 32'h2000, 1'b0);
        step(32'd2, 32'h0C, 32'h0D0E, 32'h2000, 1'b0);
        chk("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
        step(32'd1, 32'h0E, 32'h0F, 32'h2000, 1'b0);
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            chk("t3_contig", {31'd0, mem_wr_en}, 32'd1);
            idle(1, 1'b1);
        end
        chk("t3_done", {31'd0, busy}, 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) bs = 32'd0;
            else if (r < 9) bs = 32'($urandom_range(1, 4));
            else bs = 32'($urandom_range(5, 8));
            step(bs, $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0);
        end
        guard = 0;
        while (busy && guard < 100) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("rand_drained", {31'd0, busy}, 32'd0);

        // Reset in the middle of a four-byte patch, then a clean patch.
        step(32'd4, 32'h40, 32'hCAFEF00D, 32'h3000, 1'b1);
        idle(3, 1'b1);
        chk("t5_mid_patch", {31'd0, mem_wr_en}, 32'd1);
        pulse_reset();
        step(32'd3, 32'h5, 32'h00ABCDEF, 32'h4000, 1'b1);
        idle(1, 1'b1);
        chk("t5_addr0", mem_wr_addr, 32'h4005);
        chk("t5_data0", {24'd0, mem_wr_data}, 32'hAB);
        idle(4, 1'b1);

        // 2^CNT_W + 1 one-byte patches wrap the counter to 1.
        pulse_reset();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            step(32'd1, 32'(i), $urandom, 32'h8000, 1'b1);
        end
        idle(4, 1'b1);
        chk("t6_wrap", 32'(patch_count), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
